// File: rtl/tiny_nn_pkg.sv
// rtl/tiny_nn_pkg.sv - shared floating-point types and constants for the tiny_nn datapath
// Purpose : fp_t format (bfloat16-style: 1 sign, 8 exponent, 7 mantissa bits),
//           exponent bias, and the scheduler's operand bundle mul_op_t.
// Ports   : none (package)
package tiny_nn_pkg;

  localparam int FPExpWidth  = 8;
  localparam int FPMantWidth = 7;
  localparam int FPBias      = (1 << (FPExpWidth - 1)) - 1;

  typedef struct packed {
    logic                   sign;
    logic [FPExpWidth-1:0]  exp;
    logic [FPMantWidth-1:0] mant;
  } fp_t;

  // Requester id width for the default four-lane scheduler.
  localparam int MulSchedIdW = 2;

  typedef struct packed {
    logic [MulSchedIdW-1:0] id;
    fp_t                    a;
    fp_t                    b;
  } mul_op_t;

endpackage

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - combinational truncating floating-point multiplier
// Purpose : p = a * b with sign XOR, biased exponent add, one-step normalisation
//           and mantissa truncation. No rounding, no zero/inf/NaN handling.
// Ports   : a, b (fp_t operands in), p (fp_t product out)
module fp_mul
  import tiny_nn_pkg::*;
(
  input  fp_t a,
  input  fp_t b,
  output fp_t p
);

  localparam int ProdW = 2 * (FPMantWidth + 1);
  localparam int ExpW  = FPExpWidth + 2;

  logic [ProdW-1:0] prod;
  logic [ExpW-1:0]  exp_sum;
  logic             norm;
  logic             unused_bits;

  always_comb begin
    prod = {{(FPMantWidth + 1){1'b0}}, 1'b1, a.mant} *
           {{(FPMantWidth + 1){1'b0}}, 1'b1, b.mant};
    // Product of two values in [1,2) lies in [1,4): at most one right shift.
    norm = prod[ProdW-1];
    exp_sum = {2'b00, a.exp} + {2'b00, b.exp} - ExpW'(FPBias)
            + {{(ExpW - 1){1'b0}}, norm};
    p.sign = a.sign ^ b.sign;
    p.exp  = exp_sum[FPExpWidth-1:0];
    p.mant = norm ? prod[ProdW-2 -: FPMantWidth] : prod[ProdW-3 -: FPMantWidth];
  end

  // Truncated low product bits and exponent carry bits are intentionally dropped.
  assign unused_bits = ^{prod[FPMantWidth-1:0], exp_sum[ExpW-1:FPExpWidth]};

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter with internal last-grant pointer
// Purpose : picks the first requester after ptr (wrapping) when en is high;
//           ptr moves to the winner on every grant and resets to NumReq-1.
// Ports   : clk, rst_n (async active low), req[NumReq], en in;
//           gnt (one-hot), idx (winner index), valid (any grant) out.
module rr_arb #(
  parameter int NumReq = 4,
  parameter int IdW    = $clog2(NumReq)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req,
  input  logic              en,
  output logic [NumReq-1:0] gnt,
  output logic [IdW-1:0]    idx,
  output logic              valid
);

  logic [IdW-1:0] ptr;
  int             cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = (int'(ptr) + k) % NumReq;
      if (en && !valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IdW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IdW'(NumReq - 1);
    end else if (valid) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// rtl/fp_mul_sched.sv - round-robin scheduler sharing one fp_mul among NumReq lanes
// Purpose : grants one requester per cycle, registers its operands (S1), multiplies
//           and broadcasts the tagged product. Optional macro FP_MUL_SCHED_OUT_REG_EN
//           adds an output register stage (latency 2 instead of 1).
// Ports   : clk_i, rst_ni (async active low), en_i, req_i, op_a_i, op_b_i in;
//           gnt_o, rsp_valid_o, rsp_id_o, rsp_res_o, busy_o, op_cnt_o out.
module fp_mul_sched
  import tiny_nn_pkg::*;
#(
  parameter  int NumReq = 4,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [NumReq-1:0]      req_i,
  input  fp_t  [NumReq-1:0]      op_a_i,
  input  fp_t  [NumReq-1:0]      op_b_i,
  output logic [NumReq-1:0]      gnt_o,
  output logic                   rsp_valid_o,
  output logic [IdW-1:0]         rsp_id_o,
  output fp_t                    rsp_res_o,
  output logic                   busy_o,
  output logic [15:0]            op_cnt_o
);

  logic [IdW-1:0] gnt_idx;
  logic           gnt_any;
  logic           s1_valid;
  mul_op_t        s1_op;
  fp_t            mul_res;

  rr_arb #(
    .NumReq (NumReq),
    .IdW    (IdW)
  ) u_arb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   (req_i),
    .en    (en_i),
    .gnt   (gnt_o),
    .idx   (gnt_idx),
    .valid (gnt_any)
  );

  // Operand stage: the granted lane is released the same cycle, so its
  // operands must be captured here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
    end else begin
      s1_valid <= gnt_any;
      if (gnt_any) begin
        s1_op.id <= MulSchedIdW'(gnt_idx);
        s1_op.a  <= op_a_i[gnt_idx];
        s1_op.b  <= op_b_i[gnt_idx];
      end
    end
  end

  fp_mul u_mul (
    .a (s1_op.a),
    .b (s1_op.b),
    .p (mul_res)
  );

`ifdef FP_MUL_SCHED_OUT_REG_EN
  logic           out_valid;
  logic [IdW-1:0] out_id;
  fp_t            out_res;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_res   <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_id  <= IdW'(s1_op.id);
        out_res <= mul_res;
      end
    end
  end

  assign rsp_valid_o = out_valid;
  assign rsp_id_o    = out_id;
  assign rsp_res_o   = out_res;
  assign busy_o      = s1_valid | out_valid;
`else
  // Outputs are forced to zero when idle so the reset view is all zeros.
  assign rsp_valid_o = s1_valid;
  assign rsp_id_o    = s1_valid ? IdW'(s1_op.id) : '0;
  assign rsp_res_o   = s1_valid ? mul_res : '0;
  assign busy_o      = s1_valid;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_cnt_o <= '0;
    end else if (rsp_valid_o) begin
      op_cnt_o <= op_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp_mul_sched.sv
// tb/tb_fp_mul_sched.sv - scoreboard testbench for fp_mul_sched
module tb_fp_mul_sched;
  import tiny_nn_pkg::*;

`ifdef FP_MUL_SCHED_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [3:0]       req;
  fp_t  [3:0]       op_a;
  fp_t  [3:0]       op_b;
  logic [3:0]       gnt;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  fp_t              rsp_res;
  logic             busy;
  logic [15:0]      op_cnt;

  fp_mul_sched #(.NumReq(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .req_i       (req),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .gnt_o       (gnt),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_res_o   (rsp_res),
    .busy_o      (busy),
    .op_cnt_o    (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] res;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mptr = 3;
  logic [15:0] exp_cnt = 16'd0;
  bit          force_on = 1'b0;
  logic [15:0] force_res = 16'd0;

  localparam logic [15:0] F_2  = 16'h4000;
  localparam logic [15:0] F_3  = 16'h4040;
  localparam logic [15:0] F_6  = 16'h40C0;
  localparam logic [15:0] F_M15 = 16'hBFC0;
  localparam logic [15:0] F_4  = 16'h4080;
  localparam logic [15:0] F_M2 = 16'hC000;
  localparam logic [15:0] F_M6 = 16'hC0C0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real pow2(int n);
    real r;
    r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  // Exact real product of the operand values, re-encoded with truncation.
  function automatic fp_t ref_mul(fp_t a, fp_t b);
    real  va, vb, m;
    int   e;
    fp_t  r;
    va = (1.0 + real'(a.mant) / 128.0) * pow2(int'(a.exp) - 127);
    vb = (1.0 + real'(b.mant) / 128.0) * pow2(int'(b.exp) - 127);
    m  = va * vb;
    e  = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    r.sign = a.sign ^ b.sign;
    r.exp  = 8'(e + 127);
    r.mant = 7'(int'($floor((m - 1.0) * 128.0)));
    return r;
  endfunction

  function automatic fp_t rand_fp();
    fp_t r;
    r.sign = 1'($urandom);
    r.exp  = 8'($urandom_range(144, 110));
    r.mant = 7'($urandom);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req_v);
    end
  endtask

  // One clock cycle of stimulus; predicts the grant and queues the response.
  task automatic step(input logic e, input logic [3:0] r, input fp_t [3:0] a, input fp_t [3:0] b);
    int   gi;
    int   c;
    logic [3:0] eg;
    exp_t x;
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("op_cnt", 32'(op_cnt), 32'(exp_cnt));
    en = e; req = r; op_a = a; op_b = b;
    @(negedge clk);
    gi = -1;
    eg = 4'b0;
    if (e) begin
      for (int k = 1; k <= 4; k++) begin
        c = (mptr + k) % 4;
        if (gi < 0 && r[c]) gi = c;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    if (gi >= 0) begin
      x.id  = gi;
      x.res = force_on ? force_res : ref_mul(a[gi], b[gi]);
      x.due = cyc + LAT;
      q.push_back(x);
      mptr = gi;
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (q.size() != 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing id=%0d due=%0d now=%0d", q[0].id, q[0].due, cyc);
        void'(q.pop_front());
      end
      if (rsp_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rsp_spurious at cycle %0d id=%0d res=%0h", cyc, rsp_id, rsp_res);
        end else begin
          x = q.pop_front();
          if (x.due != cyc || int'(rsp_id) != x.id || rsp_res !== x.res) begin
            errors++;
            $display("FAIL rsp at cycle %0d: got id=%0d res=%0h expected id=%0d res=%0h due=%0d",
                     cyc, rsp_id, rsp_res, x.id, x.res, x.due);
          end
          exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  fp_t [3:0] za, zb, ra, rb;

  initial begin
    za = '0; zb = '0;
    rst_n = 1'b0; en = 1'b0; req = 4'b0; op_a = '0; op_b = '0;
    #23;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_op_cnt", 32'(op_cnt), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_res", 32'(rsp_res), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op 2.0 * 3.0 on lane 0.
    ra = za; rb = zb; ra[0] = F_2; rb[0] = F_3;
    force_on = 1'b1; force_res = F_6;
    step(1'b1, 4'b0001, ra, rb);
    force_on = 1'b0;
    step(1'b1, 4'b0000, za, zb);
    step(1'b1, 4'b0000, za, zb);

    // Reset while an op sits in the pipeline: no response, counters cleared.
    for (int i = 0; i < 4; i++) begin ra[i] = F_M15; rb[i] = F_4; end
    step(1'b1, 4'b1111, ra, rb);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    mptr = 3;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_op_cnt", 32'(op_cnt), 32'd0);
    chk("rst_mid_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_mid_rsp_res", 32'(rsp_res), 32'd0);
    rst_n = 1'b1;
    req = 4'b0;
    step(1'b1, 4'b1111, ra, rb);

    // Only lanes 1 and 3 requesting.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) begin ra[j] = rand_fp(); rb[j] = rand_fp(); end
      step(1'b1, 4'b1010, ra, rb);
    end

    // Enable low: no grants, pipeline drains, counter frozen.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, ra, rb);
    chk("en_off_rsp_valid", 32'(rsp_valid), 32'd0);
    step(1'b1, 4'b1111, ra, rb);

    // Continuous full load long enough to wrap op_cnt.
    for (int i = 0; i < 65600; i++) begin
      for (int j = 0; j < 4; j++) begin ra[j] = rand_fp(); rb[j] = rand_fp(); end
      step(1'b1, 4'b1111, ra, rb);
    end

    // Sign check -2.0 * 3.0.
    for (int i = 0; i < 4; i++) begin ra[i] = F_M2; rb[i] = F_3; end
    force_on = 1'b1; force_res = F_M6;
    step(1'b1, 4'b1111, ra, rb);
    force_on = 1'b0;

    // Random enable/request mix.
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 4; j++) begin ra[j] = rand_fp(); rb[j] = rand_fp(); end
      step(($urandom_range(9, 0) < 8), 4'($urandom), ra, rb);
    end

    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, za, zb);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
